// File: rtl/enable_generator_if.sv
// Control/status bundle for enable_generator: clear/hold in, strobe and count out.
// The i_hold wire exists only when ENABLE_GEN_HOLD_EN is defined.
interface enable_generator_if #(
    parameter int unsigned BIT_SIZE = 3
) ();

    logic                i_sclr;
`ifdef ENABLE_GEN_HOLD_EN
    logic                i_hold;
`endif
    logic                o_en;
    logic [BIT_SIZE-1:0] o_cnt;

`ifdef ENABLE_GEN_HOLD_EN
    modport master (output i_sclr, output i_hold, input  o_en, input  o_cnt);
    modport slave  (input  i_sclr, input  i_hold, output o_en, output o_cnt);
`else
    modport master (output i_sclr, input  o_en, input  o_cnt);
    modport slave  (input  i_sclr, output o_en, output o_cnt);
`endif

endinterface

// File: rtl/enable_generator.sv
// Free-running clock-enable generator: one-cycle o_en strobe every 2^BIT_SIZE cycles.
// Optional count freeze (i_hold) is compiled in with ENABLE_GEN_HOLD_EN.
module enable_generator #(
    parameter int unsigned BIT_SIZE = 3
) (
    input  logic               clk,
    input  logic               i_rst_n,
    enable_generator_if.slave  bus
);

    localparam logic [BIT_SIZE-1:0] CNT_MAX = '1;

    logic [BIT_SIZE-1:0] cnt_q;
    logic [BIT_SIZE-1:0] cnt_d;

    // Later assignments take priority: clear beats hold beats increment.
    always_comb begin
        // NOTE: assign a default before any condition so no path leaves cnt_d unassigned (no latch).
        cnt_d = cnt_q + BIT_SIZE'(1);
`ifdef ENABLE_GEN_HOLD_EN
        if (bus.i_hold) begin
            cnt_d = cnt_q;
        end
`endif
        if (bus.i_sclr) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        // NOTE: non-blocking assignment for registered state; async reset clears it independent of clk.
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A held all-ones count keeps the strobe high; downstream relies on that.
    assign bus.o_en  = (cnt_q == CNT_MAX);
    assign bus.o_cnt = cnt_q;

endmodule

// File: tb/tb_enable_generator.sv
// Self-checking bench for enable_generator at BIT_SIZE = 3 and BIT_SIZE = 1.
// Reference: expected count is (edges counted since last clear) mod 2^BIT_SIZE.
module tb_enable_generator;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    enable_generator_if #(.BIT_SIZE(3)) bus3 ();
    enable_generator_if #(.BIT_SIZE(1)) bus1 ();

    enable_generator #(.BIT_SIZE(3)) dut3 (.clk(clk), .i_rst_n(rst_n), .bus(bus3));
    enable_generator #(.BIT_SIZE(1)) dut1 (.clk(clk), .i_rst_n(rst_n), .bus(bus1));

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: number of counting edges since the last clear/reset.
    int phase3 = 0;
    int phase1 = 0;

    function automatic int next_phase(input int p, input logic s, input logic h);
        if (s) return 0;
`ifdef ENABLE_GEN_HOLD_EN
        if (h) return p;
`endif
        return p + 1;
    endfunction

    // Drive inputs, take one rising edge, advance the model, settle 1 time unit.
    task automatic step(input logic s3, input logic h3, input logic s1, input logic h1);
        bus3.i_sclr = s3;
        bus1.i_sclr = s1;
`ifdef ENABLE_GEN_HOLD_EN
        bus3.i_hold = h3;
        bus1.i_hold = h1;
`endif
        @(posedge clk);
        phase3 = next_phase(phase3, s3, h3);
        phase1 = next_phase(phase1, s1, h1);
        #1;
        bus3.i_sclr = 1'b0;
        bus1.i_sclr = 1'b0;
`ifdef ENABLE_GEN_HOLD_EN
        bus3.i_hold = 1'b0;
        bus1.i_hold = 1'b0;
`endif
    endtask

    task automatic test_reset();
        #1;
        n_assert++;
        if (bus3.o_cnt !== 3'd0 || bus3.o_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_initial: cnt=%0d en=%b, want cnt=0 en=0", bus3.o_cnt, bus3.o_en);
        end
        @(negedge clk);
        rst_n = 1'b1;
        phase3 = 0;
        phase1 = 0;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        n_assert++;
        if (bus3.o_cnt !== 3'd5) begin
            n_fail++;
            $display("FAIL reset_precount: cnt=%0d, want 5", bus3.o_cnt);
        end
        #3 rst_n = 1'b0;
        #1;
        n_assert++;
        if (bus3.o_cnt !== 3'd0 || bus3.o_en !== 1'b0 || bus1.o_cnt !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: cnt3=%0d en3=%b cnt1=%0d, want 0 0 0",
                     bus3.o_cnt, bus3.o_en, bus1.o_cnt);
        end
        rst_n = 1'b1;
        phase3 = 0;
        phase1 = 0;
    endtask

    task automatic test_clear_start();
        logic [2:0] want_cnt;
        step(1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            want_cnt = (k == 9) ? 3'd1 : ((k == 8) ? 3'd0 : 3'(k));
            n_assert++;
            if (bus3.o_en !== (k == 7) || bus3.o_cnt !== want_cnt) begin
                n_fail++;
                $display("FAIL clear_start edge %0d: cnt=%0d en=%b, want cnt=%0d en=%b",
                         k, bus3.o_cnt, bus3.o_en, want_cnt, (k == 7));
            end
        end
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            n_assert++;
            if (bus3.o_cnt !== 3'd0 || bus3.o_en !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_held %0d: cnt=%0d en=%b, want 0 0", k, bus3.o_cnt, bus3.o_en);
            end
        end
    endtask

    task automatic test_free_run();
        int pulses = 0;
        int last   = -1;
        logic prev = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 64; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (bus3.o_en === 1'b1) begin
                n_assert++;
                if (prev === 1'b1 || (last >= 0 && k - last != 8)) begin
                    n_fail++;
                    $display("FAIL free_run_spacing at %0d: prev_en=%b gap=%0d, want 0 and 8",
                             k, prev, k - last);
                end
                pulses++;
                last = k;
            end
            prev = bus3.o_en;
        end
        n_assert++;
        if (pulses != 8) begin
            n_fail++;
            $display("FAIL free_run_count: pulses=%0d, want 8", pulses);
        end
    endtask

    task automatic test_clear_at_max();
        int budget = 0;
        while (bus3.o_cnt !== 3'd7 && budget < 16) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            budget++;
        end
        n_assert++;
        if (bus3.o_cnt !== 3'd7 || bus3.o_en !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_max_reach: cnt=%0d en=%b, want 7 1", bus3.o_cnt, bus3.o_en);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        n_assert++;
        if (bus3.o_cnt !== 3'd0 || bus3.o_en !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_max_drop: cnt=%0d en=%b, want 0 0", bus3.o_cnt, bus3.o_en);
        end
        for (int k = 1; k <= 7; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            n_assert++;
            if (bus3.o_en !== (k == 7)) begin
                n_fail++;
                $display("FAIL clear_max_next edge %0d: en=%b, want %b", k, bus3.o_en, (k == 7));
            end
        end
    endtask

    task automatic test_bit1();
        logic [3:0] pattern = 4'b1010; // bit i = expected o_en at observation i
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step(1'b0, 1'b0, 1'b0, 1'b0);
            n_assert++;
            if (bus1.o_en !== pattern[k] || bus1.o_cnt !== pattern[k]) begin
                n_fail++;
                $display("FAIL bit1_pattern %0d: en=%b cnt=%0d, want %b", k, bus1.o_en, bus1.o_cnt, pattern[k]);
            end
        end
    endtask

`ifdef ENABLE_GEN_HOLD_EN
    task automatic test_hold();
        int budget = 0;
        int high   = 0;
        while (bus3.o_cnt !== 3'd7 && budget < 16) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            budget++;
        end
        if (bus3.o_en === 1'b1) high++;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            if (bus3.o_en === 1'b1 && bus3.o_cnt === 3'd7) high++;
        end
        n_assert++;
        if (high != 4) begin
            n_fail++;
            $display("FAIL hold_strobe: high cycles=%0d, want 4", high);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        n_assert++;
        if (bus3.o_cnt !== 3'd0 || bus3.o_en !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release: cnt=%0d en=%b, want 0 0", bus3.o_cnt, bus3.o_en);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        n_assert++;
        if (bus3.o_cnt !== 3'd0 || bus1.o_cnt !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_vs_clear: cnt3=%0d cnt1=%0d, want 0 0", bus3.o_cnt, bus1.o_cnt);
        end
    endtask
`endif

    task automatic test_random();
        logic s3, h3, s1, h1;
        logic [2:0] want3;
        logic       want1;
        for (int k = 0; k < 400; k++) begin
            s3 = ($urandom_range(15) == 0);
            s1 = ($urandom_range(15) == 0);
            h3 = ($urandom_range(3) == 0);
            h1 = ($urandom_range(3) == 0);
            step(s3, h3, s1, h1);
            want3 = 3'(phase3 % 8);
            want1 = 1'(phase1 % 2);
            n_assert++;
            if (bus3.o_cnt !== want3 || bus3.o_en !== (want3 == 3'd7) ||
                bus1.o_cnt !== want1 || bus1.o_en !== want1) begin
                n_fail++;
                $display("FAIL random step %0d: cnt3=%0d en3=%b cnt1=%0d en1=%b, want %0d %b %0d %b",
                         k, bus3.o_cnt, bus3.o_en, bus1.o_cnt, bus1.o_en,
                         want3, (want3 == 3'd7), want1, want1);
            end
        end
    endtask

    initial begin
        bus3.i_sclr = 1'b0;
        bus1.i_sclr = 1'b0;
`ifdef ENABLE_GEN_HOLD_EN
        bus3.i_hold = 1'b0;
        bus1.i_hold = 1'b0;
`endif
        test_reset();
        test_clear_start();
        test_free_run();
        test_clear_at_max();
        test_bit1();
`ifdef ENABLE_GEN_HOLD_EN
        test_hold();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
